// File: rtl/de_stage_reg.sv
// de_stage_reg: D/E pipeline register with E-stage operand forwarding from M and W.
// Stall or flush inserts a bubble; there is no hold mode.
module de_stage_reg #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = 32'h0000_3000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D_Stall,
    input  logic             E_Flush,
    input  logic [WIDTH-1:0] D_PC,
    input  logic [4:0]       D_RsNum,
    input  logic [4:0]       D_RtNum,
    input  logic [WIDTH-1:0] D_RsData,
    input  logic [WIDTH-1:0] D_RtData,
    input  logic [WIDTH-1:0] D_Ext,
    input  logic [1:0]       D_ALUOp,
    input  logic             D_ALUSrc,
    input  logic             D_RegWrite,
    input  logic [4:0]       D_WriteReg,
    input  logic             D_MemWrite,
    input  logic [1:0]       D_Tnew,
    input  logic             M_FwdValid,
    input  logic [4:0]       M_FwdReg,
    input  logic [WIDTH-1:0] M_FwdData,
    input  logic             W_FwdValid,
    input  logic [4:0]       W_FwdReg,
    input  logic [WIDTH-1:0] W_FwdData,
    output logic [WIDTH-1:0] E_ALU_A,
    output logic [WIDTH-1:0] E_ALU_B,
    output logic [1:0]       E_ALU_ALUOp,
    output logic [WIDTH-1:0] E_StoreData,
    output logic [WIDTH-1:0] E_PC,
    output logic             E_RegWrite,
    output logic [4:0]       E_WriteReg,
    output logic             E_MemWrite,
    output logic [1:0]       E_Tnew,
    output logic [4:0]       E_RsNum,
    output logic [4:0]       E_RtNum,
    output logic             E_Valid
);
    logic [WIDTH-1:0] pc_q, pc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d, ext_q, ext_d;
    logic [4:0]       rs_num_q, rs_num_d, rt_num_q, rt_num_d, write_reg_q, write_reg_d;
    logic [1:0]       alu_op_q, alu_op_d, tnew_q, tnew_d;
    logic             alu_src_q, alu_src_d, reg_write_q, reg_write_d;
    logic             mem_write_q, mem_write_d, valid_q, valid_d;
    logic             bubble;
    logic [WIDTH-1:0] rs_fwd, rt_fwd;

    always_comb begin
        bubble      = E_Flush | D_Stall;
        pc_d        = bubble ? PC_RESET : D_PC;
        rs_num_d    = bubble ? 5'd0 : D_RsNum;
        rt_num_d    = bubble ? 5'd0 : D_RtNum;
        rs_data_d   = bubble ? '0 : D_RsData;
        rt_data_d   = bubble ? '0 : D_RtData;
        ext_d       = bubble ? '0 : D_Ext;
        alu_op_d    = bubble ? 2'b00 : D_ALUOp;
        alu_src_d   = bubble ? 1'b0 : D_ALUSrc;
        reg_write_d = bubble ? 1'b0 : D_RegWrite;
        write_reg_d = bubble ? 5'd0 : D_WriteReg;
        mem_write_d = bubble ? 1'b0 : D_MemWrite;
        tnew_d      = bubble ? 2'd0 : D_Tnew;
        valid_d     = ~bubble;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q        <= PC_RESET;
            rs_num_q    <= 5'd0;
            rt_num_q    <= 5'd0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            ext_q       <= '0;
            alu_op_q    <= 2'b00;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            write_reg_q <= 5'd0;
            mem_write_q <= 1'b0;
            tnew_q      <= 2'd0;
            valid_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            rs_num_q    <= rs_num_d;
            rt_num_q    <= rt_num_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            ext_q       <= ext_d;
            alu_op_q    <= alu_op_d;
            alu_src_q   <= alu_src_d;
            reg_write_q <= reg_write_d;
            write_reg_q <= write_reg_d;
            mem_write_q <= mem_write_d;
            tnew_q      <= tnew_d;
            valid_q     <= valid_d;
        end
    end

    // $0 is never forwarded; M is younger than W so it wins on a double match
    always_comb begin
        rs_fwd = (rs_num_q == 5'd0) ? '0 :
                 (M_FwdValid && M_FwdReg == rs_num_q) ? M_FwdData :
                 (W_FwdValid && W_FwdReg == rs_num_q) ? W_FwdData : rs_data_q;
        rt_fwd = (rt_num_q == 5'd0) ? '0 :
                 (M_FwdValid && M_FwdReg == rt_num_q) ? M_FwdData :
                 (W_FwdValid && W_FwdReg == rt_num_q) ? W_FwdData : rt_data_q;
    end

    assign E_ALU_A     = rs_fwd;
    assign E_ALU_B     = alu_src_q ? ext_q : rt_fwd;
    assign E_StoreData = rt_fwd;
    assign E_ALU_ALUOp = alu_op_q;
    assign E_PC        = pc_q;
    assign E_RegWrite  = reg_write_q;
    assign E_WriteReg  = write_reg_q;
    assign E_MemWrite  = mem_write_q;
    assign E_Tnew      = tnew_q;
    assign E_RsNum     = rs_num_q;
    assign E_RtNum     = rt_num_q;
    assign E_Valid     = valid_q;
endmodule

// File: tb/tb_de_stage_reg.sv
// tb_de_stage_reg: scoreboard bench for de_stage_reg against a slot-level reference model.
module tb_de_stage_reg;
    typedef struct {
        bit rst_n, stall, flush;
        logic [31:0] pc, rsd, rtd, ext, md, wd;
        logic [4:0] rs, rt, wr, mr, wreg;
        logic [1:0] op, tn;
        bit src, rw, mw, mv, wv;
    } in_t;
    typedef struct {
        logic [31:0] pc, rsd, rtd, ext;
        logic [4:0] rs, rt, wr;
        logic [1:0] op, tn;
        bit src, rw, mw, v;
    } slot_t;
    typedef struct {
        logic [31:0] a, b, sd, pc;
        logic [4:0] wr, rsn, rtn;
        logic [1:0] op, tn;
        logic rw, mw, v;
    } out_t;

    logic clk = 0, reset, D_Stall, E_Flush, D_ALUSrc, D_RegWrite, D_MemWrite, M_FwdValid, W_FwdValid;
    logic [31:0] D_PC, D_RsData, D_RtData, D_Ext, M_FwdData, W_FwdData;
    logic [4:0] D_RsNum, D_RtNum, D_WriteReg, M_FwdReg, W_FwdReg;
    logic [1:0] D_ALUOp, D_Tnew;
    logic [31:0] E_ALU_A, E_ALU_B, E_StoreData, E_PC;
    logic [1:0] E_ALU_ALUOp, E_Tnew;
    logic E_RegWrite, E_MemWrite, E_Valid;
    logic [4:0] E_WriteReg, E_RsNum, E_RtNum;

    int checks = 0, failures = 0;
    out_t sb[$];
    slot_t slot;
    bit known = 0;

    de_stage_reg dut (
        .clk(clk), .reset(reset), .D_Stall(D_Stall), .E_Flush(E_Flush), .D_PC(D_PC),
        .D_RsNum(D_RsNum), .D_RtNum(D_RtNum), .D_RsData(D_RsData), .D_RtData(D_RtData),
        .D_Ext(D_Ext), .D_ALUOp(D_ALUOp), .D_ALUSrc(D_ALUSrc), .D_RegWrite(D_RegWrite),
        .D_WriteReg(D_WriteReg), .D_MemWrite(D_MemWrite), .D_Tnew(D_Tnew),
        .M_FwdValid(M_FwdValid), .M_FwdReg(M_FwdReg), .M_FwdData(M_FwdData),
        .W_FwdValid(W_FwdValid), .W_FwdReg(W_FwdReg), .W_FwdData(W_FwdData),
        .E_ALU_A(E_ALU_A), .E_ALU_B(E_ALU_B), .E_ALU_ALUOp(E_ALU_ALUOp),
        .E_StoreData(E_StoreData), .E_PC(E_PC), .E_RegWrite(E_RegWrite),
        .E_WriteReg(E_WriteReg), .E_MemWrite(E_MemWrite), .E_Tnew(E_Tnew),
        .E_RsNum(E_RsNum), .E_RtNum(E_RtNum), .E_Valid(E_Valid)
    );

    always #5 clk = ~clk;

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{pc: 32'h0000_3000, rsd: 0, rtd: 0, ext: 0, rs: 0, rt: 0, wr: 0, op: 0, tn: 0,
              src: 0, rw: 0, mw: 0, v: 0};
        return s;
    endfunction

    // Value an E-stage reader sees for register r: youngest producer wins, $0 is always zero
    function automatic logic [31:0] read_reg(logic [4:0] r, logic [31:0] held, in_t v);
        if (r == 0) return 0;
        if (v.mv && v.mr == r) return v.md;
        if (v.wv && v.wreg == r) return v.wd;
        return held;
    endfunction

    function automatic out_t expect_out(slot_t s, in_t v);
        out_t o;
        o.a = read_reg(s.rs, s.rsd, v);
        o.sd = read_reg(s.rt, s.rtd, v);
        o.b = s.src ? s.ext : o.sd;
        o.pc = s.pc; o.wr = s.wr; o.rsn = s.rs; o.rtn = s.rt;
        o.op = s.op; o.tn = s.tn; o.rw = s.rw; o.mw = s.mw; o.v = s.v;
        return o;
    endfunction

    function automatic in_t idle_in();
        in_t v;
        v = '{rst_n: 1, stall: 0, flush: 0, pc: 32'h3004, rsd: 0, rtd: 0, ext: 0, md: 0, wd: 0,
              rs: 0, rt: 0, wr: 0, mr: 0, wreg: 0, op: 0, tn: 0,
              src: 0, rw: 0, mw: 0, mv: 0, wv: 0};
        return v;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.rst_n = ($urandom_range(0, 19) != 0);
        v.stall = ($urandom_range(0, 5) == 0);
        v.flush = ($urandom_range(0, 5) == 0);
        v.pc = $urandom; v.rsd = $urandom; v.rtd = $urandom; v.ext = $urandom;
        v.md = $urandom; v.wd = $urandom;
        v.rs = 5'($urandom_range(0, 3)); v.rt = 5'($urandom_range(0, 3));
        v.mr = 5'($urandom_range(0, 3)); v.wreg = 5'($urandom_range(0, 3));
        v.wr = 5'($urandom); v.op = 2'($urandom_range(0, 2)); v.tn = 2'($urandom);
        v.src = 1'($urandom); v.rw = 1'($urandom); v.mw = 1'($urandom);
        v.mv = 1'($urandom); v.wv = 1'($urandom);
        return v;
    endfunction

    task automatic drive(in_t v);
        reset = v.rst_n; D_Stall = v.stall; E_Flush = v.flush; D_PC = v.pc;
        D_RsNum = v.rs; D_RtNum = v.rt; D_RsData = v.rsd; D_RtData = v.rtd; D_Ext = v.ext;
        D_ALUOp = v.op; D_ALUSrc = v.src; D_RegWrite = v.rw; D_WriteReg = v.wr;
        D_MemWrite = v.mw; D_Tnew = v.tn;
        M_FwdValid = v.mv; M_FwdReg = v.mr; M_FwdData = v.md;
        W_FwdValid = v.wv; W_FwdReg = v.wreg; W_FwdData = v.wd;
    endtask

    // One cycle: apply inputs, queue what the current slot must show, then advance the model at the edge
    task automatic step(in_t v);
        drive(v);
        if (known) sb.push_back(expect_out(slot, v));
        @(posedge clk);
        if (!v.rst_n || v.flush || v.stall) slot = empty_slot();
        else slot = '{pc: v.pc, rsd: v.rsd, rtd: v.rtd, ext: v.ext, rs: v.rs, rt: v.rt, wr: v.wr,
                      op: v.op, tn: v.tn, src: v.src, rw: v.rw, mw: v.mw, v: 1};
        if (!v.rst_n) known = 1;
        #1;
    endtask

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            out_t e;
            e = sb.pop_front();
            chk("E_ALU_A", E_ALU_A, e.a);
            chk("E_ALU_B", E_ALU_B, e.b);
            chk("E_StoreData", E_StoreData, e.sd);
            chk("E_ALU_ALUOp", 32'(E_ALU_ALUOp), 32'(e.op));
            chk("E_PC", E_PC, e.pc);
            chk("E_RegWrite", 32'(E_RegWrite), 32'(e.rw));
            chk("E_WriteReg", 32'(E_WriteReg), 32'(e.wr));
            chk("E_MemWrite", 32'(E_MemWrite), 32'(e.mw));
            chk("E_Tnew", 32'(E_Tnew), 32'(e.tn));
            chk("E_RsNum", 32'(E_RsNum), 32'(e.rsn));
            chk("E_RtNum", 32'(E_RtNum), 32'(e.rtn));
            chk("E_Valid", 32'(E_Valid), 32'(e.v));
        end
    end

    initial begin
        in_t v;
        v = idle_in();
        v.rst_n = 0; v.op = 2'b01; v.pc = 32'h3004;
        step(v);
        step(v);
        v = idle_in(); v.rs = 8; v.rt = 9; v.rsd = 5; v.rtd = 3; v.op = 2'b01; v.rw = 1; v.wr = 10; v.tn = 2;
        step(v);
        v.src = 1; v.ext = 32'hFFFF_FFFC;
        step(v);
        v.src = 0; v.mv = 1; v.mr = 8; v.md = 32'h11; v.wv = 1; v.wreg = 8; v.wd = 32'h22;
        step(v);
        v.mv = 0;
        step(v);
        v = idle_in(); v.rs = 0; v.rt = 0; v.rw = 1; v.wr = 0;
        step(v);
        v.mv = 1; v.mr = 0; v.md = 32'hDEAD; v.wv = 1; v.wreg = 0; v.wd = 32'hBEEF;
        step(v);
        v = idle_in(); v.rs = 4; v.rsd = 7; v.rw = 1; v.tn = 3; v.wr = 4;
        step(v);
        v.stall = 1;
        step(v);
        v.stall = 0; v.pc = 32'h3010;
        step(v);
        v.flush = 1;
        step(v);
        v.flush = 0;
        step(v);
        v.rst_n = 0; v.stall = 1;
        step(v);
        v.rst_n = 1; v.stall = 0; v.pc = 32'h3020; v.mw = 1;
        step(v);
        step(idle_in());
        for (int i = 0; i < 400; i++) step(rand_in());
        step(idle_in());
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
